// File: rtl/com_uart_rx_controller_if.sv
// Read port of the UART receive queue: head character, its error flags and a valid/ready handshake.
interface com_uart_rx_controller_if;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       rd_frame_err;
    logic       rd_valid;
    logic       rd_ready;

    modport master (output rd_data, rd_parity_err, rd_frame_err, rd_valid, input rd_ready);
    modport slave  (input rd_data, rd_parity_err, rd_frame_err, rd_valid, output rd_ready);
endinterface

// File: rtl/com_uart_rx_controller.sv
// UART receive sequencer: 16x oversampled framing (5-8 data, opt. parity, 1-2 stop) into a read queue.
// Latency: entry pushed on the final stop-sample tick, rd_valid one clk later; reader stalls via rd_ready.
// Macro COM_UART_RX_FIFO_EN selects a DEPTH-entry FIFO, otherwise a single holding register; full queue drops and sets overflow.
module com_uart_rx_controller #(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tick_16x,
    input  logic                            rx_port,
    input  logic                            stop_bit_config,
    input  logic [1:0]                      parity_bit_config,
    input  logic [1:0]                      data_bit_config,
    input  logic                            clr_overflow,
    com_uart_rx_controller_if.master        rd,
    output logic                            overflow,
    output logic                            busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_t;

    state_t     state;
    logic       sync1, rx;
    logic [3:0] scnt;
    logic [2:0] bcnt;
    logic [2:0] nbits_m1;
    logic [7:0] sr;
    logic       par_en, par_odd, two_stop;
    logic       perr, ferr;
    logic       sample, push, pop, accept, drop, full;
    logic [9:0] entry, head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= rx_port;
            rx    <= sync1;
        end
    end

    assign sample = tick_16x && (scnt == 4'd15);
    assign entry  = {ferr | ~rx, perr, sr};

    always_comb begin
        push = 1'b0;
        if (sample) begin
            case (state)
                STOP1:   push = ~rx | ~two_stop;
                STOP2:   push = 1'b1;
                default: push = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            scnt     <= '0;
            bcnt     <= '0;
            nbits_m1 <= '0;
            sr       <= '0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            two_stop <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else if (tick_16x) begin
            case (state)
                IDLE: begin
                    if (!rx) begin
                        state <= START;
                        scnt  <= '0;
                    end
                end
                START: begin
                    if (scnt == 4'd7) begin
                        if (!rx) begin
                            state    <= DATA;
                            scnt     <= '0;
                            bcnt     <= '0;
                            sr       <= '0;
                            perr     <= 1'b0;
                            ferr     <= 1'b0;
                            nbits_m1 <= 3'd4 + {1'b0, data_bit_config};
                            par_en   <= parity_bit_config[1];
                            par_odd  <= parity_bit_config[0];
                            two_stop <= stop_bit_config;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        scnt <= scnt + 4'd1;
                    end
                end
                DATA: begin
                    scnt <= scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        sr[bcnt] <= rx;
                        if (bcnt == nbits_m1) state <= par_en ? PARITY : STOP1;
                        else                  bcnt  <= bcnt + 3'd1;
                    end
                end
                PARITY: begin
                    scnt <= scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        // unused upper bits of sr are zero, so ^sr is the data parity
                        perr  <= (^sr) ^ rx ^ par_odd;
                        state <= STOP1;
                    end
                end
                STOP1: begin
                    scnt <= scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        if (!rx) begin
                            ferr  <= 1'b1;
                            state <= WAIT_HIGH;
                        end else begin
                            state <= two_stop ? STOP2 : IDLE;
                        end
                    end
                end
                STOP2: begin
                    scnt <= scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        ferr  <= ~rx;
                        state <= rx ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rx) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign pop    = rd.rd_valid & rd.rd_ready;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

`ifdef COM_UART_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;

    assign full        = (cnt == (AW+1)'(DEPTH));
    assign rd.rd_valid = (cnt != '0);
    assign head        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
`else
    logic [9:0] hold;
    logic       hold_vld;

    // DEPTH has no effect on the single holding register
    if (DEPTH < 1) begin : g_depth_unused
    end

    assign full        = hold_vld;
    assign rd.rd_valid = hold_vld;
    assign head        = hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= '0;
            hold_vld <= 1'b0;
        end else if (accept) begin
            hold     <= entry;
            hold_vld <= 1'b1;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end
`endif

    assign rd.rd_data       = rd.rd_valid ? head[7:0] : 8'd0;
    assign rd.rd_parity_err = rd.rd_valid & head[8];
    assign rd.rd_frame_err  = rd.rd_valid & head[9];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end
endmodule

// File: tb/tb_com_uart_rx_controller.sv
// Bench for com_uart_rx_controller: directed scenarios plus random frames against a frame-level queue model.
module tb_com_uart_rx_controller;
`ifdef COM_UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_16x = 1'b0;
    logic       rx_port = 1'b1;
    logic       stop_bit_config = 1'b0;
    logic [1:0] parity_bit_config = 2'b00;
    logic [1:0] data_bit_config = 2'b11;
    logic       clr_overflow = 1'b0;
    logic       overflow, busy;

    com_uart_rx_controller_if rif();

    com_uart_rx_controller #(.DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .tick_16x          (tick_16x),
        .rx_port           (rx_port),
        .stop_bit_config   (stop_bit_config),
        .parity_bit_config (parity_bit_config),
        .data_bit_config   (data_bit_config),
        .clr_overflow      (clr_overflow),
        .rd                (rif),
        .overflow          (overflow),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       f;
    } ent_t;

    ent_t expq[$];
    ent_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rd_en   = 1'b0;
    logic exp_ovf = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one tick every third clk
    initial begin
        int tc;
        tc = 0;
        forever begin
            @(negedge clk);
            tick_16x = (tc == 0);
            tc = (tc == 2) ? 0 : tc + 1;
        end
    end

    // consumer: random ready, every accepted head compared with the model queue
    initial begin
        rif.rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            rif.rd_ready = rd_en && !rst && ($urandom_range(0, 1) == 1);
            if (rif.rd_ready && rif.rd_valid) begin
                if (expq.size() == 0) begin
                    check_val("spurious_pop", rif.rd_valid, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check_val("rd_data", rif.rd_data, mon_e.d);
                    check_val("rd_parity_err", rif.rd_parity_err, mon_e.p);
                    check_val("rd_frame_err", rif.rd_frame_err, mon_e.f);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick_16x) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] dbc, input logic [1:0] pc,
                              input logic sb2, input logic flip_par, input logic s1, input logic s2,
                              input bit scramble);
        int         nb;
        logic [8:0] m;
        logic [7:0] dm;
        logic       pbit;
        ent_t       e;
        nb   = 5 + int'(dbc);
        m    = (9'd1 << nb) - 9'd1;
        dm   = d & m[7:0];
        pbit = (^dm) ^ pc[0] ^ flip_par;
        e.d  = dm;
        e.p  = pc[1] & flip_par;
        e.f  = !s1 || (sb2 && !s2);
        if (expq.size() < CAP) expq.push_back(e);
        else                   exp_ovf = 1'b1;
        data_bit_config   = dbc;
        parity_bit_config = pc;
        stop_bit_config   = sb2;
        rx_port = 1'b0;
        wait_ticks(16);
        if (scramble) begin
            data_bit_config   = 2'($urandom);
            parity_bit_config = 2'($urandom);
            stop_bit_config   = 1'($urandom);
        end
        for (int i = 0; i < nb; i++) begin
            rx_port = d[i];
            wait_ticks(16);
        end
        if (pc[1]) begin
            rx_port = pbit;
            wait_ticks(16);
        end
        rx_port = s1;
        wait_ticks(16);
        if (sb2 && s1) begin
            rx_port = s2;
            wait_ticks(16);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        rd_en = 1'b1;
        while (expq.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_val("drain_done", expq.size(), 0);
        repeat (3) @(negedge clk);
        check_val("queue_empty", rif.rd_valid, 0);
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check_val("rst_rd_valid", rif.rd_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("reset_rd_valid", rif.rd_valid, 0);
        check_val("reset_rd_data", rif.rd_data, 0);
        check_val("reset_perr", rif.rd_parity_err, 0);
        check_val("reset_ferr", rif.rd_frame_err, 0);
        check_val("reset_overflow", overflow, 0);
        check_val("reset_busy", busy, 0);
        wait_ticks(4);

        // 8N1 0xA5, held in the queue while rd_ready stays low
        send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_val("a5_valid", rif.rd_valid, 1);
        check_val("a5_data", rif.rd_data, 8'hA5);
        check_val("a5_perr", rif.rd_parity_err, 0);
        repeat (5) @(negedge clk);
        check_val("a5_stable", rif.rd_data, 8'hA5);
        drain();

        // 7E2 0x35, parity bit forced wrong then correct
        send_frame(8'h35, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h35, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();

        // 5N1 start glitch of 4 ticks
        data_bit_config = 2'b00;
        rx_port = 1'b0;
        wait_ticks(4);
        rx_port = 1'b1;
        wait_ticks(2);
        check_val("glitch_busy", busy, 1);
        wait_ticks(8);
        check_val("glitch_idle", busy, 0);
        wait_ticks(4);
        check_val("glitch_no_entry", rif.rd_valid, 0);

        // framing error followed by a break
        send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_ticks(40);
        check_val("break_busy", busy, 1);
        rx_port = 1'b1;
        wait_ticks(4);
        check_val("break_released", busy, 0);
        send_frame(8'h11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        rx_port = 1'b1;
        drain();

        // overflow with the reader stalled
        rd_en = 1'b0;
        exp_ovf = 1'b0;
        wait_ticks(4);
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            wait_ticks(4);
        end
        @(negedge clk);
        check_val("ovf_set", overflow, exp_ovf);
        drain();
        check_val("ovf_sticky", overflow, exp_ovf);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        check_val("ovf_cleared", overflow, exp_ovf);

        // reset in the middle of 0x77 with an entry already queued
        rd_en = 1'b0;
        send_frame(8'h5A, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_ticks(4);
        b = 8'h77;
        rx_port = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx_port = b[i];
            wait_ticks(16);
        end
        check_val("mid_frame_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expq.delete();
        check_val("rst_mid_valid", rif.rd_valid, 0);
        check_val("rst_mid_data", rif.rd_data, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_ovf", overflow, 0);
        rx_port = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(20);
        check_val("post_rst_valid", rif.rd_valid, 0);
        rd_en = 1'b1;
        send_frame(8'h42, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        rx_port = 1'b1;
        drain();

        // random frames with mid-frame config changes
        for (int k = 0; k < 20; k++) begin
            send_frame(8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), 1'b1);
            rx_port = 1'b1;
            wait_ticks(20);
            drain();
        end
        check_val("ovf_final", overflow, exp_ovf);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
